// File: rtl/partition_boundary_tx_pkg.sv
// Shared definitions for the partition boundary-value transmitter:
// default widths and the FSM state encoding.
package partition_boundary_tx_pkg;

    localparam int SINGLE_W    = 32;
    localparam int DEF_NUM_VAL = 8;
    localparam int DEF_IDX_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_SEND    = 2'd2
    } tx_state_t;

endpackage

// File: rtl/partition_boundary_tx_if.sv
// Solver-side bus of the boundary-value transmitter: write/control inputs
// and the streamed output toward the neighbouring partition.
interface partition_boundary_tx_if #(
    parameter int WIDTH = partition_boundary_tx_pkg::SINGLE_W,
    parameter int IDX_W = partition_boundary_tx_pkg::DEF_IDX_W
);
    logic             step_start;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [WIDTH-1:0] wr_data;
    logic             send_req;
    logic             err_clr;
    logic [WIDTH-1:0] cout;
    logic [IDX_W-1:0] cout_idx;
    logic             control_valuation_sig;
    logic             frame_done;
    logic             busy;
    logic             stale_err;
    logic             overrun_err;

    modport master (
        output step_start, wr_en, wr_idx, wr_data, send_req, err_clr,
        input  cout, cout_idx, control_valuation_sig, frame_done, busy,
               stale_err, overrun_err
    );

    modport slave (
        input  step_start, wr_en, wr_idx, wr_data, send_req, err_clr,
        output cout, cout_idx, control_valuation_sig, frame_done, busy,
               stale_err, overrun_err
    );
endinterface

// File: rtl/partition_value_buf.sv
// NUM_VAL x WIDTH boundary-value register file with one write port, one
// write-through read port and a per-slot valid bitmap with clear.
module partition_value_buf import partition_boundary_tx_pkg::*; #(
    parameter int WIDTH   = SINGLE_W,
    parameter int NUM_VAL = DEF_NUM_VAL,
    parameter int IDX_W   = DEF_IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_clr,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_all_valid
);

    logic [WIDTH-1:0]   r_mem [NUM_VAL];
    logic [NUM_VAL-1:0] r_valid;
    logic [NUM_VAL-1:0] w_wr_onehot;

    always_comb begin
        w_wr_onehot = '0;
        for (int i = 0; i < NUM_VAL; i++) begin
            if (i_wr_en && (i_wr_idx == IDX_W'(i))) begin
                w_wr_onehot[i] = 1'b1;
            end
        end
    end

    // A same-cycle write is visible on the read port so a write that lands
    // with send_req is part of the frame's first captured word.
    always_comb begin
        o_rd_data = '0;
        for (int i = 0; i < NUM_VAL; i++) begin
            if (i_rd_idx == IDX_W'(i)) begin
                o_rd_data = w_wr_onehot[i] ? i_wr_data : r_mem[i];
            end
        end
    end

    assign o_all_valid = &(r_valid | w_wr_onehot);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VAL; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_VAL; i++) begin
                if (w_wr_onehot[i]) begin
                    r_mem[i] <= i_wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (i_clr) begin
            r_valid <= w_wr_onehot;
        end else begin
            r_valid <= r_valid | w_wr_onehot;
        end
    end

endmodule

// File: rtl/partition_boundary_tx.sv
// Sending end of the inter-partition boundary link: collects one timestep's
// boundary values and streams them one per cycle on send_req.
module partition_boundary_tx import partition_boundary_tx_pkg::*; #(
    parameter int WIDTH   = SINGLE_W,
    parameter int NUM_VAL = DEF_NUM_VAL,
    parameter int IDX_W   = DEF_IDX_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    partition_boundary_tx_if.slave  bnd
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VAL - 1);

    tx_state_t        r_state;
    tx_state_t        w_state_next;
    logic [IDX_W-1:0] r_ptr;
    logic [WIDTH-1:0] r_cout;
    logic [IDX_W-1:0] r_cout_idx;
    logic             r_strobe;
    logic             r_done;
    logic             r_stale_err;
    logic             r_overrun_err;

    logic             w_idx_ok;
    logic             w_buf_wr;
    logic             w_buf_clr;
    logic             w_all_valid;
    logic [WIDTH-1:0] w_rd_data;
    logic [IDX_W-1:0] w_rd_idx;
    logic             w_load;
    logic             w_stale_evt;
    logic             w_overrun_evt;

    assign w_idx_ok  = {1'b0, bnd.wr_idx} < (IDX_W + 1)'(NUM_VAL);
    assign w_buf_wr  = (r_state == ST_COLLECT) && bnd.wr_en && w_idx_ok;
    assign w_buf_clr = bnd.step_start &&
                       ((r_state == ST_IDLE) ||
                        ((r_state == ST_COLLECT) && !bnd.send_req));
    assign w_stale_evt = (r_state == ST_COLLECT) && bnd.send_req && !w_all_valid;

    partition_value_buf #(
        .WIDTH   (WIDTH),
        .NUM_VAL (NUM_VAL),
        .IDX_W   (IDX_W)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_wr_en     (w_buf_wr),
        .i_wr_idx    (bnd.wr_idx),
        .i_wr_data   (bnd.wr_data),
        .i_clr       (w_buf_clr),
        .i_rd_idx    (w_rd_idx),
        .o_rd_data   (w_rd_data),
        .o_all_valid (w_all_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (bnd.step_start) w_state_next = ST_COLLECT;
            ST_COLLECT: if (bnd.send_req)   w_state_next = ST_SEND;
            ST_SEND:    if (r_ptr == LAST_IDX) w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // w_load fetches the next slot into the output registers: slot 0 when a
    // frame is accepted, then one slot per cycle until the last has gone out.
    always_comb begin
        w_load        = 1'b0;
        w_rd_idx      = r_ptr + 1'b1;
        w_overrun_evt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_overrun_evt = bnd.wr_en;
            end
            ST_COLLECT: begin
                w_overrun_evt = bnd.wr_en && !w_idx_ok;
                if (bnd.send_req) begin
                    w_load   = 1'b1;
                    w_rd_idx = '0;
                end
            end
            ST_SEND: begin
                w_overrun_evt = bnd.wr_en || bnd.step_start || bnd.send_req;
                w_load        = (r_ptr != LAST_IDX);
            end
            default: begin
                w_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_cout     <= '0;
            r_cout_idx <= '0;
            r_strobe   <= 1'b0;
            r_done     <= 1'b0;
        end else if (w_load) begin
            r_ptr      <= w_rd_idx;
            r_cout     <= w_rd_data;
            r_cout_idx <= w_rd_idx;
            r_strobe   <= 1'b1;
            r_done     <= (w_rd_idx == LAST_IDX);
        end else begin
            r_strobe   <= 1'b0;
            r_done     <= 1'b0;
        end
    end

    // A new error event wins over a coincident err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stale_err   <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_stale_err   <= w_stale_evt   || (r_stale_err   && !bnd.err_clr);
            r_overrun_err <= w_overrun_evt || (r_overrun_err && !bnd.err_clr);
        end
    end

    assign bnd.cout                  = r_cout;
    assign bnd.cout_idx              = r_cout_idx;
    assign bnd.control_valuation_sig = r_strobe;
    assign bnd.frame_done            = r_done;
    assign bnd.busy                  = (r_state != ST_IDLE);
    assign bnd.stale_err             = r_stale_err;
    assign bnd.overrun_err           = r_overrun_err;

endmodule

// File: tb/tb_partition_boundary_tx.sv
// Self-checking bench for partition_boundary_tx: directed scenarios plus a
// randomized run, all checked every cycle against a frame-level model.
module tb_partition_boundary_tx;

    localparam int WIDTH   = 32;
    localparam int NUM_VAL = 8;
    localparam int IDX_W   = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    partition_boundary_tx_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bif();

    partition_boundary_tx #(
        .WIDTH   (WIDTH),
        .NUM_VAL (NUM_VAL),
        .IDX_W   (IDX_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bnd   (bif)
    );

    always #5 clk = ~clk;

    // Model: 0 idle, 1 collecting, 2 sending; a frame is a snapshot of the
    // buffer taken when send_req is accepted.
    logic [31:0] m_buf   [NUM_VAL];
    logic [31:0] m_frame [NUM_VAL];
    bit          m_valid [NUM_VAL];
    int          m_phase = 0;
    int          m_k     = 0;
    logic [31:0] e_cout  = '0;
    int          e_idx   = 0;
    bit          e_strobe = 0, e_done = 0, e_stale = 0, e_over = 0;
    bit          ev_stale, ev_over;

    logic [31:0] cap_data [NUM_VAL];
    int          cap_total = 0;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VAL; i++) begin
                m_buf[i]   = '0;
                m_valid[i] = 0;
            end
            m_phase = 0; m_k = 0;
            e_cout = '0; e_idx = 0; e_strobe = 0; e_done = 0;
            e_stale = 0; e_over = 0;
        end else begin
            ev_stale = 0;
            ev_over  = 0;
            if (m_phase == 2) begin
                if (bif.wr_en || bif.step_start || bif.send_req) ev_over = 1;
                if (m_k == NUM_VAL - 1) begin
                    m_phase = 0; e_strobe = 0; e_done = 0;
                end else begin
                    m_k++;
                    e_cout = m_frame[m_k]; e_idx = m_k; e_strobe = 1;
                    e_done = (m_k == NUM_VAL - 1);
                end
            end else if (m_phase == 1) begin
                if (bif.step_start && !bif.send_req)
                    for (int i = 0; i < NUM_VAL; i++) m_valid[i] = 0;
                if (bif.wr_en) begin
                    if (int'(bif.wr_idx) < NUM_VAL) begin
                        m_buf[bif.wr_idx]   = bif.wr_data;
                        m_valid[bif.wr_idx] = 1;
                    end else begin
                        ev_over = 1;
                    end
                end
                if (bif.send_req) begin
                    for (int i = 0; i < NUM_VAL; i++) begin
                        if (!m_valid[i]) ev_stale = 1;
                        m_frame[i] = m_buf[i];
                    end
                    m_phase = 2; m_k = 0;
                    e_cout = m_frame[0]; e_idx = 0; e_strobe = 1; e_done = 0;
                end
            end else begin
                if (bif.wr_en) ev_over = 1;
                if (bif.step_start) begin
                    m_phase = 1;
                    for (int i = 0; i < NUM_VAL; i++) m_valid[i] = 0;
                end
            end
            e_stale = ev_stale || (e_stale && !bif.err_clr);
            e_over  = ev_over  || (e_over  && !bif.err_clr);
        end
    end

    always @(negedge clk) begin
        checkOutput("strobe",      32'(bif.control_valuation_sig), 32'(e_strobe));
        checkOutput("frame_done",  32'(bif.frame_done),  32'(e_done));
        checkOutput("busy",        32'(bif.busy),        32'(m_phase != 0));
        checkOutput("cout",        bif.cout,             e_cout);
        checkOutput("cout_idx",    32'(bif.cout_idx),    32'(e_idx));
        checkOutput("stale_err",   32'(bif.stale_err),   32'(e_stale));
        checkOutput("overrun_err", 32'(bif.overrun_err), 32'(e_over));
        if (bif.control_valuation_sig) begin
            cap_data[bif.cout_idx] = bif.cout;
            cap_total++;
        end
    end

    task automatic applyStimulus(input bit step, input bit wr, input int idx,
                                 input logic [31:0] data, input bit send,
                                 input bit clr);
        bif.step_start = step;
        bif.wr_en      = wr;
        bif.wr_idx     = IDX_W'(idx);
        bif.wr_data    = data;
        bif.send_req   = send;
        bif.err_clr    = clr;
        @(posedge clk);
        #1;
        bif.step_start = 0; bif.wr_en = 0; bif.wr_idx = '0;
        bif.wr_data = '0; bif.send_req = 0; bif.err_clr = 0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(0, 0, 0, 32'h0, 0, 0);
    endtask

    task automatic fillFrame(input logic [31:0] base, input int count);
        applyStimulus(1, 0, 0, 32'h0, 0, 0);
        for (int k = 0; k < count; k++)
            applyStimulus(0, 1, k, base + 32'(k), 0, 0);
    endtask

    int base_cnt;

    initial begin
        bif.step_start = 0; bif.wr_en = 0; bif.wr_idx = '0;
        bif.wr_data = '0; bif.send_req = 0; bif.err_clr = 0;
        #1 rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        checkOutput("reset_busy",  32'(bif.busy), 32'h0);
        checkOutput("reset_cout",  bif.cout,      32'h0);
        checkOutput("reset_strobe", 32'(bif.control_valuation_sig), 32'h0);

        // Nominal frame
        base_cnt = cap_total;
        fillFrame(32'h3F800000, NUM_VAL);
        applyStimulus(0, 0, 0, 32'h0, 1, 0);
        checkOutput("t1_first_strobe", 32'(bif.control_valuation_sig), 32'h1);
        checkOutput("t1_first_idx",    32'(bif.cout_idx), 32'h0);
        idleCycles(NUM_VAL - 1);
        checkOutput("t1_done_last", 32'(bif.frame_done), 32'h1);
        checkOutput("t1_busy_last", 32'(bif.busy),       32'h1);
        idleCycles(1);
        checkOutput("t1_busy_fall", 32'(bif.busy), 32'h0);
        checkOutput("t1_count", 32'(cap_total - base_cnt), 32'(NUM_VAL));
        for (int k = 0; k < NUM_VAL; k++)
            checkOutput("t1_data", cap_data[k], 32'h3F800000 + 32'(k));
        checkOutput("t1_stale", 32'(bif.stale_err),   32'h0);
        checkOutput("t1_over",  32'(bif.overrun_err), 32'h0);

        // Stale slot carries previous frame's value
        fillFrame(32'h40000000, NUM_VAL - 1);
        applyStimulus(0, 0, 0, 32'h0, 1, 0);
        idleCycles(NUM_VAL + 1);
        checkOutput("t2_stale", 32'(bif.stale_err), 32'h1);
        checkOutput("t2_slot0", cap_data[0], 32'h40000000);
        checkOutput("t2_slot7", cap_data[7], 32'h3F800007);
        applyStimulus(0, 0, 0, 32'h0, 0, 1);
        checkOutput("t2_clr", 32'(bif.stale_err), 32'h0);

        // Same-cycle write+send, and last write wins
        applyStimulus(1, 0, 0, 32'h0, 0, 0);
        for (int k = 0; k < NUM_VAL; k++)
            if (k != 3) applyStimulus(0, 1, k, 32'h41000000 + 32'(k), 0, 0);
        applyStimulus(0, 1, 5, 32'h4A000000, 0, 0);
        applyStimulus(0, 1, 3, 32'h40400000, 1, 0);
        idleCycles(NUM_VAL + 1);
        checkOutput("t3_slot3", cap_data[3], 32'h40400000);
        checkOutput("t3_slot5", cap_data[5], 32'h4A000000);
        checkOutput("t3_stale", 32'(bif.stale_err), 32'h0);

        // Writes during SEND and in IDLE are violations
        fillFrame(32'h42000000, NUM_VAL);
        applyStimulus(0, 0, 0, 32'h0, 1, 0);
        idleCycles(2);
        applyStimulus(0, 1, 2, 32'hDEADBEEF, 0, 0);
        idleCycles(NUM_VAL - 1);
        checkOutput("t4_over",  32'(bif.overrun_err), 32'h1);
        checkOutput("t4_slot2", cap_data[2], 32'h42000002);
        applyStimulus(0, 0, 0, 32'h0, 0, 1);
        checkOutput("t4_clr", 32'(bif.overrun_err), 32'h0);
        applyStimulus(0, 1, 1, 32'h12345678, 0, 0);
        checkOutput("t4_idle_wr", 32'(bif.overrun_err), 32'h1);
        applyStimulus(0, 0, 0, 32'h0, 0, 1);

        // Asynchronous reset after the third strobe
        fillFrame(32'h43000000, NUM_VAL);
        applyStimulus(0, 0, 0, 32'h0, 1, 0);
        idleCycles(2);
        #1 rst_n = 0;
        #1;
        checkOutput("t5_strobe", 32'(bif.control_valuation_sig), 32'h0);
        checkOutput("t5_busy",   32'(bif.busy), 32'h0);
        checkOutput("t5_cout",   bif.cout,      32'h0);
        @(posedge clk);
        #1 rst_n = 1;
        base_cnt = cap_total;
        fillFrame(32'h44000000, NUM_VAL);
        applyStimulus(0, 0, 0, 32'h0, 1, 0);
        idleCycles(NUM_VAL + 1);
        checkOutput("t5_count", 32'(cap_total - base_cnt), 32'(NUM_VAL));
        checkOutput("t5_slot7", cap_data[7], 32'h44000007);

        // Restart after four writes
        fillFrame(32'h45000000, 4);
        applyStimulus(1, 0, 0, 32'h0, 0, 0);
        applyStimulus(0, 0, 0, 32'h0, 1, 0);
        idleCycles(NUM_VAL + 1);
        checkOutput("t6_stale", 32'(bif.stale_err), 32'h1);
        checkOutput("t6_slot0", cap_data[0], 32'h45000000);
        applyStimulus(0, 0, 0, 32'h0, 0, 1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            applyStimulus($urandom_range(0, 99) < 4,
                          $urandom_range(0, 99) < 40,
                          int'($urandom_range(0, NUM_VAL - 1)),
                          $urandom,
                          $urandom_range(0, 99) < 5,
                          $urandom_range(0, 99) < 3);
        end
        idleCycles(NUM_VAL + 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
